// File: rtl/short_stack_unit.sv
// short_stack_unit
//   Per-ray short stack for kd-restart traversal. Executes PUSH / POP / UPDATE
//   commands from trav_unit against a RAM addressed {rayID, ptr}. The stack
//   pointers travel with the ray, so no per-ray pointer state is held here.
//   A POP yields a resume request (top entry) or a restart request (empty
//   stack) toward tarb; PUSH and UPDATE produce no output.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   trav_to_ss_valid / _stall   command handshake (stall is combinational)
//   ss_op                       00 PUSH, 01 POP, 10 UPDATE, 11 NOP
//   ss_rayID, ss_wptr, ss_num   ray and its stack pointer / entry count
//   ss_nodeID, ss_t_max         command payload
//   ss_to_tarb_valid / _stall   request handshake toward tarb
//   ss_to_tarb_*                request fields
//   ss_drop_cnt                 saturating count of PUSHes that overwrote an entry
module short_stack_unit #(
  parameter int unsigned        RAYID_W = 9,
  parameter int unsigned        DEPTH   = 4,
  parameter int unsigned        PTR_W   = 2,
  parameter int unsigned        NUM_W   = 3,
  parameter int unsigned        NODE_W  = 16,
  parameter logic [NODE_W-1:0]  ROOT_ID = '0,
  parameter logic [31:0]        T_INF   = 32'h7F800000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trav_to_ss_valid,
  output logic               trav_to_ss_stall,
  input  logic [1:0]         ss_op,
  input  logic [RAYID_W-1:0] ss_rayID,
  input  logic [PTR_W-1:0]   ss_wptr,
  input  logic [NUM_W-1:0]   ss_num,
  input  logic [NODE_W-1:0]  ss_nodeID,
  input  logic [31:0]        ss_t_max,
  output logic               ss_to_tarb_valid,
  input  logic               ss_to_tarb_stall,
  output logic [RAYID_W-1:0] ss_to_tarb_rayID,
  output logic [NODE_W-1:0]  ss_to_tarb_nodeID,
  output logic [31:0]        ss_to_tarb_t_min,
  output logic [31:0]        ss_to_tarb_t_max,
  output logic               ss_to_tarb_restnode_search,
  output logic [PTR_W-1:0]   ss_to_tarb_ss_wptr,
  output logic [NUM_W-1:0]   ss_to_tarb_ss_num,
  output logic [15:0]        ss_drop_cnt
);

  typedef enum logic [1:0] {
    OP_PUSH   = 2'b00,
    OP_POP    = 2'b01,
    OP_UPDATE = 2'b10,
    OP_NOP    = 2'b11
  } op_e;

  localparam int unsigned AW    = RAYID_W + PTR_W;
  localparam int unsigned ENT_W = NODE_W + 32;

  logic [ENT_W-1:0] mem [0:(1<<AW)-1];

  // S1 stage
  logic               s1_valid;
  op_e                s1_op;
  logic [RAYID_W-1:0] s1_ray;
  logic [PTR_W-1:0]   s1_wptr;
  logic [NUM_W-1:0]   s1_num;
  logic [NODE_W-1:0]  s1_node;
  logic [31:0]        s1_tmax;
  logic [ENT_W-1:0]   s1_rdata;

  logic               accept;
  logic               s1_adv;
  logic               out_ld;
  logic               s1_nonempty;
  logic [PTR_W-1:0]   s1_wptr_dec;
  logic [AW-1:0]      raddr;
  logic [ENT_W-1:0]   rdata;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [ENT_W-1:0]   wdata;

  assign s1_nonempty = (s1_num != '0);
  assign s1_wptr_dec = s1_wptr - PTR_W'(1);

  // Only a POP can be held in S1: it needs OUT, nothing else does.
  assign s1_adv           = s1_valid & ~((s1_op == OP_POP) & ss_to_tarb_valid & ss_to_tarb_stall);
  assign trav_to_ss_stall = s1_valid & ~s1_adv;
  assign accept           = trav_to_ss_valid & ~trav_to_ss_stall;
  assign out_ld           = ~ss_to_tarb_valid | ~ss_to_tarb_stall;

  // Commit from S1. UPDATE rewrites the whole entry, reusing the nodeID read in
  // S0, so the S0 bypass below can forward a single full-width word.
  always_comb begin
    we    = 1'b0;
    waddr = {s1_ray, s1_wptr};
    wdata = {s1_node, s1_tmax};
    if (s1_adv) begin
      unique case (s1_op)
        OP_PUSH:   we = 1'b1;
        OP_UPDATE: begin
          we    = s1_nonempty;
          waddr = {s1_ray, s1_wptr_dec};
          wdata = {s1_rdata[ENT_W-1 -: NODE_W], s1_tmax};
        end
        default:   we = 1'b0;
      endcase
    end
  end

  // Read the top-of-stack for the incoming command, forwarding a same-cycle
  // commit to the same address so back-to-back commands see the new data.
  assign raddr = {ss_rayID, ss_wptr - PTR_W'(1)};
  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_NOP;
      s1_ray   <= '0;
      s1_wptr  <= '0;
      s1_num   <= '0;
      s1_node  <= '0;
      s1_tmax  <= '0;
      s1_rdata <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op_e'(ss_op);
      s1_ray   <= ss_rayID;
      s1_wptr  <= ss_wptr;
      s1_num   <= ss_num;
      s1_node  <= ss_nodeID;
      s1_tmax  <= ss_t_max;
      s1_rdata <= rdata;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_to_tarb_valid           <= 1'b0;
      ss_to_tarb_rayID           <= '0;
      ss_to_tarb_nodeID          <= '0;
      ss_to_tarb_t_min           <= '0;
      ss_to_tarb_t_max           <= '0;
      ss_to_tarb_restnode_search <= 1'b0;
      ss_to_tarb_ss_wptr         <= '0;
      ss_to_tarb_ss_num          <= '0;
    end else if (out_ld) begin
      ss_to_tarb_valid <= s1_adv && (s1_op == OP_POP);
      if (s1_adv && (s1_op == OP_POP)) begin
        ss_to_tarb_rayID <= s1_ray;
        ss_to_tarb_t_min <= s1_tmax;
        if (s1_nonempty) begin
          ss_to_tarb_nodeID          <= s1_rdata[ENT_W-1 -: NODE_W];
          ss_to_tarb_t_max           <= s1_rdata[31:0];
          ss_to_tarb_restnode_search <= 1'b0;
          ss_to_tarb_ss_wptr         <= s1_wptr_dec;
          ss_to_tarb_ss_num          <= s1_num - NUM_W'(1);
        end else begin
          ss_to_tarb_nodeID          <= ROOT_ID;
          ss_to_tarb_t_max           <= T_INF;
          ss_to_tarb_restnode_search <= 1'b1;
          ss_to_tarb_ss_wptr         <= s1_wptr;
          ss_to_tarb_ss_num          <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_drop_cnt <= '0;
    end else if (s1_adv && (s1_op == OP_PUSH) && (s1_num == NUM_W'(DEPTH)) && (ss_drop_cnt != '1)) begin
      ss_drop_cnt <= ss_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_short_stack_unit.sv
// tb_short_stack_unit
//   Directed plus random-stall checks of short_stack_unit against a small
//   behavioural stack model; expected POP results are queued on acceptance and
//   compared when the request leaves toward tarb.
module tb_short_stack_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trav_to_ss_valid = 1'b0;
  logic        trav_to_ss_stall;
  logic [1:0]  ss_op = '0;
  logic [8:0]  ss_rayID = '0;
  logic [1:0]  ss_wptr = '0;
  logic [2:0]  ss_num = '0;
  logic [15:0] ss_nodeID = '0;
  logic [31:0] ss_t_max = '0;
  logic        ss_to_tarb_valid;
  logic        ss_to_tarb_stall = 1'b0;
  logic [8:0]  ss_to_tarb_rayID;
  logic [15:0] ss_to_tarb_nodeID;
  logic [31:0] ss_to_tarb_t_min;
  logic [31:0] ss_to_tarb_t_max;
  logic        ss_to_tarb_restnode_search;
  logic [1:0]  ss_to_tarb_ss_wptr;
  logic [2:0]  ss_to_tarb_ss_num;
  logic [15:0] ss_drop_cnt;

  short_stack_unit #(
    .RAYID_W(9), .DEPTH(4), .PTR_W(2), .NUM_W(3), .NODE_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .trav_to_ss_valid(trav_to_ss_valid), .trav_to_ss_stall(trav_to_ss_stall),
    .ss_op(ss_op), .ss_rayID(ss_rayID), .ss_wptr(ss_wptr), .ss_num(ss_num),
    .ss_nodeID(ss_nodeID), .ss_t_max(ss_t_max),
    .ss_to_tarb_valid(ss_to_tarb_valid), .ss_to_tarb_stall(ss_to_tarb_stall),
    .ss_to_tarb_rayID(ss_to_tarb_rayID), .ss_to_tarb_nodeID(ss_to_tarb_nodeID),
    .ss_to_tarb_t_min(ss_to_tarb_t_min), .ss_to_tarb_t_max(ss_to_tarb_t_max),
    .ss_to_tarb_restnode_search(ss_to_tarb_restnode_search),
    .ss_to_tarb_ss_wptr(ss_to_tarb_ss_wptr), .ss_to_tarb_ss_num(ss_to_tarb_ss_num),
    .ss_drop_cnt(ss_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [94:0] f;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [47:0] mdl [0:511][0:3];
  logic [15:0] exp_drop = '0;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          rand_en = 1'b0;
  logic [1:0]  rwp  [0:3];
  logic [2:0]  rnum [0:3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ss_to_tarb_stall = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [8:0] ray, input logic [1:0] wp,
                             input logic [2:0] num, input logic [15:0] node, input logic [31:0] tm,
                             input int acc);
    logic [1:0] pm;
    exp_t       e;
    pm = wp - 2'd1;
    case (op)
      2'b00: begin
        mdl[ray][wp] = {node, tm};
        if (num == 3'd4 && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end
      2'b01: begin
        if (num != 3'd0)
          e.f = {ray, mdl[ray][pm][47:32], tm, mdl[ray][pm][31:0], 1'b0, pm, num - 3'd1};
        else
          e.f = {ray, 16'h0000, tm, 32'h7F800000, 1'b1, wp, 3'd0};
        e.acc = acc;
        q.push_back(e);
      end
      2'b10: if (num != 3'd0) mdl[ray][pm][31:0] = tm;
      default: ;
    endcase
  endtask

  // Called just after a posedge; returns just after the posedge of acceptance.
  task automatic send(input logic [1:0] op, input logic [8:0] ray, input logic [1:0] wp,
                      input logic [2:0] num, input logic [15:0] node, input logic [31:0] tm);
    bit done;
    done = 1'b0;
    chk("num_legal", {127'd0, num <= 3'd4}, 128'd1);
    ss_op = op; ss_rayID = ray; ss_wptr = wp; ss_num = num; ss_nodeID = node; ss_t_max = tm;
    trav_to_ss_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!trav_to_ss_stall) begin
        model_apply(op, ray, wp, num, node, tm, cyc);
        done = 1'b1;
      end
      @(posedge clk);
    end
    #1;
    trav_to_ss_valid = 1'b0;
    chk("accepted", {127'd0, done}, 128'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) tick();
    repeat (2) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ss_to_tarb_valid && !ss_to_tarb_stall) begin
        chk("out_expected", {127'd0, q.size() != 0}, 128'd1);
        if (q.size() != 0) begin
          me = q.pop_front();
          chk("out_fields", {ss_to_tarb_rayID, ss_to_tarb_nodeID, ss_to_tarb_t_min, ss_to_tarb_t_max,
                             ss_to_tarb_restnode_search, ss_to_tarb_ss_wptr, ss_to_tarb_ss_num}, me.f);
          if (!rand_en) chk("pop_latency", cyc - me.acc, 2);
        end
      end
      if (trav_to_ss_stall)
        chk("stall_cause", {ss_to_tarb_valid, ss_to_tarb_stall}, 2'b11);
    end
  end

  initial begin
    logic [8:0] ray;
    int         r;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", ss_to_tarb_valid, 0);
    chk("rst_stall", trav_to_ss_stall, 0);
    chk("rst_drop", ss_drop_cnt, 0);
    chk("rst_fields", {ss_to_tarb_rayID, ss_to_tarb_nodeID, ss_to_tarb_t_min, ss_to_tarb_t_max,
                       ss_to_tarb_restnode_search, ss_to_tarb_ss_wptr, ss_to_tarb_ss_num}, 0);
    tick();

    // Reset while a PUSH sits in S1 and valid stays high: nothing may be written.
    send(2'b00, 9'd5, 2'd0, 3'd0, 16'h1111, 32'h3F800000);
    repeat (3) tick();
    ss_op = 2'b00; ss_rayID = 9'd5; ss_wptr = 2'd0; ss_num = 3'd4;
    ss_nodeID = 16'h2222; ss_t_max = 32'h0;
    trav_to_ss_valid = 1'b1;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    trav_to_ss_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", ss_to_tarb_valid, 0);
    chk("mid_rst_drop", ss_drop_cnt, 0);
    chk("mid_rst_stall", trav_to_ss_stall, 0);
    tick();
    send(2'b01, 9'd5, 2'd1, 3'd1, 16'h0, 32'h40000000);
    drain();

    // Ray 6: PUSH then POP back-to-back (bypass).
    send(2'b00, 9'd6, 2'd0, 3'd0, 16'd12, 32'h41200000);
    send(2'b01, 9'd6, 2'd1, 3'd1, 16'd0, 32'h40A00000);
    drain();

    // Ray 3: POP on empty stack -> restart.
    send(2'b01, 9'd3, 2'd0, 3'd0, 16'd0, 32'h40800000);
    drain();

    // Ray 4: five PUSHes wrap the ring and overwrite one entry.
    for (int i = 0; i < 5; i++)
      send(2'b00, 9'd4, 2'(i), (i > 4) ? 3'd4 : 3'(i), 16'(i + 1), 32'(i));
    send(2'b01, 9'd4, 2'd1, 3'd4, 16'd0, 32'h3F000000);
    drain();
    chk("drop_after_wrap", ss_drop_cnt, 16'd1);

    // Ray 7: PUSH, UPDATE, POP back-to-back.
    send(2'b00, 9'd7, 2'd0, 3'd0, 16'd9, 32'h41000000);
    send(2'b10, 9'd7, 2'd1, 3'd1, 16'd0, 32'h40400000);
    send(2'b01, 9'd7, 2'd1, 3'd1, 16'd0, 32'h3F800000);
    drain();

    // Random mix on rays 0..3 with 50% downstream stall.
    for (int i = 0; i < 4; i++) begin
      rwp[i] = '0;
      rnum[i] = '0;
    end
    rand_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ray = 9'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        send(2'b00, ray, rwp[ray[1:0]], rnum[ray[1:0]], 16'($urandom), $urandom);
        rwp[ray[1:0]] = rwp[ray[1:0]] + 2'd1;
        if (rnum[ray[1:0]] != 3'd4) rnum[ray[1:0]] = rnum[ray[1:0]] + 3'd1;
      end else if (r <= 6) begin
        send(2'b01, ray, rwp[ray[1:0]], rnum[ray[1:0]], 16'($urandom), $urandom);
        if (rnum[ray[1:0]] != 3'd0) begin
          rwp[ray[1:0]]  = rwp[ray[1:0]] - 2'd1;
          rnum[ray[1:0]] = rnum[ray[1:0]] - 3'd1;
        end
      end else if (r <= 8) begin
        send(2'b10, ray, rwp[ray[1:0]], rnum[ray[1:0]], 16'($urandom), $urandom);
      end else begin
        send(2'b11, ray, rwp[ray[1:0]], rnum[ray[1:0]], 16'($urandom), $urandom);
      end
    end
    rand_en = 1'b0;
    drain();
    chk("final_drop", ss_drop_cnt, exp_drop);
    chk("final_valid", ss_to_tarb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
